clock_monitor: RTL and testbench

// - Measures an incoming carrier clock (nominal 13.56 MHz, e.g. from the analogue front end or a clock BFM).
// - clk_in is treated as data, sampled on a faster local clock.
// - Counts clk_in rising edges per fixed window and reports the count.
// - Flags in-tolerance frequency and loss of carrier.
// - Sits between the analogue clock input and digital control logic that gates operation on a valid carrier.
//

---
 rtl/clock_monitor.sv | 178 +++++++++++++++++
 tb/tb_clock_monitor.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_monitor.sv
// clock_monitor
//   Measures a carrier clock (nominally 13.56 MHz) that is treated as data and
//   sampled on the faster local clock. It counts clk_in rising edges over
//   fixed windows of WINDOW_CYCLES local cycles. It reports each completed
//   window's count, flags whether that count is within tolerance of the
//   nominal value, and flags loss of carrier.
//
// Ports
//   clk          in   local sampling clock (>= 3x clk_in)
//   rst          in   synchronous, active-high reset
//   clk_in       in   monitored clock, asynchronous to clk
//   enable       in   1 = measure, 0 = idle (aborts the running window)
//   edge_count   out  edge count of the last completed MEASURE window
//   count_valid  out  one-cycle pulse when edge_count updates
//   freq_ok      out  last window count within +/-TOLERANCE of EXPECTED_EDGES
//   clk_lost     out  no clk_in edge seen for LOSS_TIMEOUT cycles
module clock_monitor #(
    parameter int  WINDOW_CYCLES  = 1000,
    parameter int  EXPECTED_EDGES = 135,
    parameter int  TOLERANCE      = 2,
    parameter int  LOSS_TIMEOUT   = 32,
    localparam int CNT_W          = $clog2(WINDOW_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_in,
    input  logic             enable,
    output logic [CNT_W-1:0] edge_count,
    output logic             count_valid,
    output logic             freq_ok,
    output logic             clk_lost
);

    localparam int LOSS_W = $clog2(LOSS_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]        WIN_LAST = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0]        CNT_MAX  = '1;
    localparam logic [LOSS_W-1:0]       LOSS_MAX = LOSS_W'(LOSS_TIMEOUT);
    localparam logic signed [CNT_W:0]   EXP_S    = (CNT_W + 1)'(EXPECTED_EDGES);
    localparam logic signed [CNT_W:0]   TOL_S    = (CNT_W + 1)'(TOLERANCE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               sync3_q, sync3_d;
    logic [CNT_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LOSS_W-1:0]  loss_q, loss_d;
    logic [CNT_W-1:0]   edge_count_q, edge_count_d;
    logic               count_valid_q, count_valid_d;
    logic               freq_ok_q, freq_ok_d;
    logic               clk_lost_q, clk_lost_d;

    logic               edge_det;
    logic               win_end;
    logic [CNT_W-1:0]   cnt_inc;
    logic signed [CNT_W:0] diff_s;
    logic               in_tol;

    always_comb begin
        // Two synchroniser flops, then a third purely for rising-edge detect.
        sync1_d  = clk_in;
        sync2_d  = sync1_q;
        sync3_d  = sync2_q;
        edge_det = sync2_q & ~sync3_q;
        win_end  = (win_q == WIN_LAST);

        // Count including this cycle's edge, so an edge on the window-end
        // cycle lands in the closing window. Saturates instead of wrapping.
        cnt_inc = (edge_det && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;
        diff_s  = $signed({1'b0, cnt_inc}) - EXP_S;
        in_tol  = (diff_s <= TOL_S) && (diff_s >= -TOL_S);

        state_d       = state_q;
        win_d         = win_q;
        cnt_d         = cnt_q;
        loss_d        = loss_q;
        edge_count_d  = edge_count_q;
        count_valid_d = 1'b0;
        freq_ok_d     = freq_ok_q;
        clk_lost_d    = clk_lost_q;

        case (state_q)
            ST_IDLE: begin
                win_d      = '0;
                cnt_d      = '0;
                loss_d     = '0;
                freq_ok_d  = 1'b0;
                clk_lost_d = 1'b0;
                if (enable) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE, ST_MEASURE: begin
                if (!enable) begin
                    // Abort the running window; edge_count keeps its value.
                    state_d    = ST_IDLE;
                    win_d      = '0;
                    cnt_d      = '0;
                    loss_d     = '0;
                    freq_ok_d  = 1'b0;
                    clk_lost_d = 1'b0;
                end else begin
                    if (edge_det) begin
                        loss_d = '0;
                    end else if (loss_q != LOSS_MAX) begin
                        loss_d = loss_q + LOSS_W'(1);
                    end
                    clk_lost_d = (loss_d == LOSS_MAX);

                    if (win_end) begin
                        win_d = '0;
                        cnt_d = '0;
                        if (state_q == ST_MEASURE) begin
                            edge_count_d  = cnt_inc;
                            count_valid_d = 1'b1;
                            freq_ok_d     = in_tol;
                        end else begin
                            // The settle window's count is thrown away.
                            state_d = ST_MEASURE;
                        end
                    end else begin
                        win_d = win_q + CNT_W'(1);
                        cnt_d = cnt_inc;
                    end

                    // A lost carrier can never be reported as in tolerance.
                    if (clk_lost_d) begin
                        freq_ok_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            sync3_q       <= 1'b0;
            win_q         <= '0;
            cnt_q         <= '0;
            loss_q        <= '0;
            edge_count_q  <= '0;
            count_valid_q <= 1'b0;
            freq_ok_q     <= 1'b0;
            clk_lost_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            sync3_q       <= sync3_d;
            win_q         <= win_d;
            cnt_q         <= cnt_d;
            loss_q        <= loss_d;
            edge_count_q  <= edge_count_d;
            count_valid_q <= count_valid_d;
            freq_ok_q     <= freq_ok_d;
            clk_lost_q    <= clk_lost_d;
        end
    end

    assign edge_count  = edge_count_q;
    assign count_valid = count_valid_q;
    assign freq_ok     = freq_ok_q;
    assign clk_lost    = clk_lost_q;

endmodule

// File: tb/tb_clock_monitor.sv
// tb_clock_monitor
//   Bench for clock_monitor. A phase-accumulator clock source produces clk_in
//   at a chosen ratio to the 100 MHz local clock. A reference model built from
//   edge timestamps predicts every output on every cycle: a rise sampled at
//   local cycle n is counted two cycles later, and windows are fixed spans of
//   cycles measured from the cycle enable was taken.
`timescale 1ns/1ps
module tb_clock_monitor;

    localparam int W     = 1000;
    localparam int EXP   = 135;
    localparam int TOL   = 2;
    localparam int LT    = 32;
    localparam int CNT_W = 10;
    localparam int NMAX  = 65536;

    logic             clk    = 1'b0;
    logic             rst    = 1'b1;
    logic             clk_in = 1'b0;
    logic             enable = 1'b0;
    logic [CNT_W-1:0] edge_count;
    logic             count_valid;
    logic             freq_ok;
    logic             clk_lost;

    always #5 clk = ~clk;

    clock_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .clk_in      (clk_in),
        .enable      (enable),
        .edge_count  (edge_count),
        .count_valid (count_valid),
        .freq_ok     (freq_ok),
        .clk_lost    (clk_lost)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Rising edges of clk_in as seen at each local sample point.
    bit rise [0:NMAX-1];
    bit prev_in = 1'b0;

    // Reference model state.
    bit               m_act = 1'b0;
    int               m_e = 0;
    int               m_wcnt = 0;
    int               m_last = 0;
    logic [CNT_W-1:0] exp_ec = '0;
    bit               exp_cv = 1'b0;
    bit               exp_fok = 1'b0;
    bit               exp_lost = 1'b0;

    // Clock source: clk_in frequency = step/10000 of the local clock.
    bit bfm_on = 1'b1;
    bit hold   = 1'b0;
    int phase  = 0;
    int step   = 1356;

    function automatic bit in_tol(int c);
        return ((c - EXP) <= TOL) && ((EXP - c) <= TOL);
    endfunction

    function automatic logic [CNT_W+2:0] got_vec();
        return {edge_count, count_valid, freq_ok, clk_lost};
    endfunction

    function automatic logic [CNT_W+2:0] exp_vec();
        return {exp_ec, exp_cv, exp_fok, exp_lost};
    endfunction

    // Advance one local cycle, update the model from the inputs sampled on
    // that edge, then drive clk_in for the next edge.
    task automatic tick();
        int j;
        int k;
        bit e_now;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (cyc < NMAX) rise[cyc] = !rst && clk_in && !prev_in;
        prev_in = rst ? 1'b0 : clk_in;
        e_now   = (cyc >= 2) ? rise[cyc-2] : 1'b0;
        exp_cv  = 1'b0;
        if (rst) begin
            m_act       = 1'b0;
            exp_ec      = '0;
            exp_fok     = 1'b0;
            exp_lost    = 1'b0;
            rise[cyc-1] = 1'b0;
        end else if (!m_act) begin
            exp_fok  = 1'b0;
            exp_lost = 1'b0;
            if (enable) begin
                m_act  = 1'b1;
                m_e    = cyc;
                m_last = cyc;
            end
        end else if (!enable) begin
            m_act    = 1'b0;
            exp_fok  = 1'b0;
            exp_lost = 1'b0;
        end else begin
            j = (cyc - m_e - 1) % W;
            k = (cyc - m_e - 1) / W;
            if (j == 0) m_wcnt = 0;
            if (e_now) begin
                m_wcnt++;
                m_last = cyc;
            end
            exp_lost = (cyc - m_last) >= LT;
            if (j == W - 1 && k >= 1) begin
                exp_cv  = 1'b1;
                exp_ec  = CNT_W'(m_wcnt);
                exp_fok = in_tol(m_wcnt);
            end
            if (exp_lost) exp_fok = 1'b0;
        end
        if (bfm_on) begin
            phase  = (phase + step) % 10000;
            clk_in = !hold && (phase < 5000);
        end
        if (exp_cv)
            $display("window cyc=%0d edge_count=%0d (model %0d) freq_ok=%0b clk_lost=%0b",
                     cyc, edge_count, exp_ec, freq_ok, clk_lost);
    endtask

    task automatic idle_restart(input int new_step);
        enable = 1'b0;
        repeat (5) tick();
        step   = new_step;
        phase  = int'($urandom % 10000);
        enable = 1'b1;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        enable = 1'b0;
        repeat (6) begin
            tick();
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_model cyc=%0d got=%b want=%b", cyc, got_vec(), exp_vec());
            end
        end
        checks++;
        if (got_vec() !== '0) begin
            errors++;
            $display("FAIL reset_zero got=%b want=0", got_vec());
        end
        rst = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_nominal();
        int pulses = 0;
        idle_restart(1356);
        for (int i = 0; i < 4 * W + 5; i++) begin
            tick();
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL nominal_model cyc=%0d got=%b want=%b", cyc, got_vec(), exp_vec());
            end
            if (count_valid) begin
                pulses++;
                checks++;
                if (!(edge_count == 135 || edge_count == 136) || !freq_ok || clk_lost) begin
                    errors++;
                    $display("FAIL nominal_band count=%0d ok=%0b lost=%0b want 135/136,1,0",
                             edge_count, freq_ok, clk_lost);
                end
            end
        end
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL nominal_pulses got=%0d want=3", pulses);
        end
    endtask

    task automatic test_slow();
        bit seen = 1'b0;
        idle_restart(1200);
        for (int i = 0; i < 2 * W + 5; i++) begin
            tick();
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL slow_model cyc=%0d got=%b want=%b", cyc, got_vec(), exp_vec());
            end
            if (count_valid && !seen) begin
                seen = 1'b1;
                checks++;
                if (!(edge_count == 120 || edge_count == 121) || freq_ok) begin
                    errors++;
                    $display("FAIL slow_band count=%0d ok=%0b want 120/121,0", edge_count, freq_ok);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL slow_no_pulse got=0 want=1");
        end
    endtask

    task automatic test_random_freq();
        for (int it = 0; it < 4; it++) begin
            idle_restart(int'($urandom_range(1310, 1400)));
            for (int i = 0; i < 2 * W + 5; i++) begin
                tick();
                checks++;
                if (got_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL random_model step=%0d cyc=%0d got=%b want=%b",
                             step, cyc, got_vec(), exp_vec());
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        logic [CNT_W-1:0] held;
        int pulses = 0;
        idle_restart(1356);
        tick();
        while (cyc < m_e + 2 * W + 500) tick();
        held   = edge_count;
        enable = 1'b0;
        tick();
        checks++;
        if (count_valid || freq_ok || clk_lost || edge_count !== held) begin
            errors++;
            $display("FAIL drop_idle got cv=%0b ok=%0b lost=%0b ec=%0d want 0,0,0,%0d",
                     count_valid, freq_ok, clk_lost, edge_count, held);
        end
        for (int i = 0; i < 1200; i++) begin
            tick();
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL drop_idle_model cyc=%0d got=%b want=%b", cyc, got_vec(), exp_vec());
            end
        end
        enable = 1'b1;
        for (int i = 0; i < 2 * W + 5; i++) begin
            tick();
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL drop_reenable_model cyc=%0d got=%b want=%b", cyc, got_vec(), exp_vec());
            end
            if (count_valid) pulses++;
            if (i == W + 1) begin
                checks++;
                if (pulses != 0) begin
                    errors++;
                    $display("FAIL drop_settle_pulse got=%0d want=0", pulses);
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL drop_reenable_pulses got=%0d want=1", pulses);
        end
    endtask

    task automatic test_lost();
        int n_last = -1;
        int first_lost = -1;
        int n_r = -1;
        int clr = -1;
        idle_restart(1356);
        tick();
        while (cyc < m_e + 2 * W + 300) tick();
        hold = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL lost_model cyc=%0d got=%b want=%b", cyc, got_vec(), exp_vec());
            end
            if (clk_lost && first_lost < 0) begin
                first_lost = cyc;
                checks++;
                if (freq_ok) begin
                    errors++;
                    $display("FAIL lost_freq_ok got=1 want=0");
                end
            end
        end
        for (int n = cyc; n > cyc - 100; n--) if (n_last < 0 && rise[n]) n_last = n;
        checks++;
        if (first_lost < 0 || first_lost - n_last > 35 || first_lost - n_last < 32) begin
            errors++;
            $display("FAIL lost_timing got=%0d want 32..35 cycles after last edge", first_lost - n_last);
        end
        hold = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL lost_restart_model cyc=%0d got=%b want=%b", cyc, got_vec(), exp_vec());
            end
            if (n_r < 0 && rise[cyc]) n_r = cyc;
            if (clr < 0 && !clk_lost) clr = cyc;
        end
        checks++;
        if (n_r < 0 || clr < 0 || clr - n_r > 3) begin
            errors++;
            $display("FAIL lost_clear got=%0d want <=3 cycles after restart", clr - n_r);
        end
    endtask

    task automatic test_rst_mid();
        int pulses = 0;
        idle_restart(1356);
        repeat (1500) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (got_vec() !== '0 || got_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL rst_mid got=%b want=0", got_vec());
        end
        enable = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        enable = 1'b1;
        for (int i = 0; i < 3 * W + 5; i++) begin
            tick();
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rst_recover_model cyc=%0d got=%b want=%b", cyc, got_vec(), exp_vec());
            end
            if (count_valid) begin
                pulses++;
                checks++;
                if (!(edge_count == 135 || edge_count == 136) || !freq_ok) begin
                    errors++;
                    $display("FAIL rst_recover_band count=%0d ok=%0b want 135/136,1", edge_count, freq_ok);
                end
            end
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL rst_recover_pulses got=%0d want=2", pulses);
        end
    endtask

    task automatic test_window_edge();
        int e;
        enable = 1'b0;
        repeat (5) tick();
        bfm_on = 1'b0;
        clk_in = 1'b0;
        repeat (3) tick();
        enable = 1'b1;
        tick();
        e = m_e;
        // Rises sampled at e+W+10 and e+2W-2 belong to window 1 (the latter is
        // counted on its last cycle); the one at e+2W belongs to window 2.
        while (cyc < e + 3 * W + 3) begin
            clk_in = ((cyc + 1) == e + W + 10) || ((cyc + 1) == e + 2 * W - 2) ||
                     ((cyc + 1) == e + 2 * W);
            tick();
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL edge_model cyc=%0d got=%b want=%b", cyc, got_vec(), exp_vec());
            end
            if (cyc == e + 2 * W) begin
                checks++;
                if (!count_valid || edge_count !== 2) begin
                    errors++;
                    $display("FAIL edge_closing got cv=%0b count=%0d want 1,2", count_valid, edge_count);
                end
            end
            if (cyc == e + 3 * W) begin
                checks++;
                if (!count_valid || edge_count !== 1) begin
                    errors++;
                    $display("FAIL edge_next got cv=%0b count=%0d want 1,1", count_valid, edge_count);
                end
            end
        end
        bfm_on = 1'b1;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_slow();
        test_random_freq();
        test_enable_drop();
        test_lost();
        test_rst_mid();
        test_window_edge();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
